// File: rtl/tone_dec_pkg.sv
// Shared constants and types for the tone period decoder: note thresholds,
// output field widths and the measurement FSM states.
package tone_dec_pkg;

  localparam int unsigned NOTE_W    = 4;
  localparam int unsigned OCT_W     = 4;
  localparam int unsigned NUM_NOTES = 12;

  // Normalized-period thresholds; entry 0 is the lowest.
  localparam logic [NUM_NOTES-1:0][7:0] NOTE_THRESH = {
    8'd247, 8'd233, 8'd220, 8'd208, 8'd196, 8'd185,
    8'd175, 8'd165, 8'd156, 8'd147, 8'd139, 8'd131
  };

  typedef enum logic {
    IDLE,
    MEASURE
  } state_e;

endpackage

// File: rtl/tone_note_classify.sv
// Combinational period classifier: leading-zero count, 8-bit normalization and
// threshold compare, producing pitch class and octave code.
module tone_note_classify
  import tone_dec_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic [CNT_W-1:0]  period_i,
  output logic [NOTE_W-1:0] note_o,
  output logic [OCT_W-1:0]  octave_o
);

  localparam int unsigned LZ_W = $clog2(CNT_W + 1);

  logic [LZ_W-1:0]  lz;
  logic [CNT_W-1:0] norm;
  logic [7:0]       mant;
  logic [3:0]       n;

  always_comb begin
    lz = LZ_W'(CNT_W);
    // Scan upward so the highest set bit determines the count.
    for (int i = 0; i < CNT_W; i++) begin
      if (period_i[i]) lz = LZ_W'(int'(CNT_W) - 1 - i);
    end
    norm = period_i << lz;
    mant = norm[CNT_W-1 -: 8];

    n = 4'd0;
    for (int k = 0; k < NUM_NOTES; k++) begin
      if (mant >= NOTE_THRESH[k]) n = n + 4'd1;
    end

    if (n < 4'(NUM_NOTES)) begin
      note_o   = NOTE_W'(n);
      octave_o = OCT_W'(lz);
    end else if (lz != '0) begin
      // Above the top threshold the note belongs to the next octave down in lz.
      note_o   = '0;
      octave_o = OCT_W'(lz - LZ_W'(1));
    end else begin
      note_o   = NOTE_W'(NUM_NOTES - 1);
      octave_o = '0;
    end
  end

endmodule

// File: rtl/tone_period_decoder.sv
// Measures the period of a 1-bit tone line between rising edges, tracks period
// stability for lock, and classifies each period into note and octave.
module tone_period_decoder
  import tone_dec_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned STABLE_N  = 4,
  parameter int unsigned TOL_SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              tone_i,
  output logic [CNT_W-1:0]  period_o,
  output logic              period_valid_o,
  output logic              locked_o,
  output logic              silence_o,
  output logic [NOTE_W-1:0] note_o,
  output logic [OCT_W-1:0]  octave_o,
  output logic              note_valid_o
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [3:0]       STABLE_MAX = 4'(STABLE_N);

  logic s1_q, s2_q, prev_q, rise;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   prev_period_q, prev_period_d;
  logic               have_prev_q, have_prev_d;
  logic [3:0]         stable_q, stable_d;
  logic               period_valid_q, period_valid_d;
  logic               locked_q, locked_d;
  logic               silence_q, silence_d;
  logic [NOTE_W-1:0]  note_q, note_d, cls_note;
  logic [OCT_W-1:0]   octave_q, octave_d, cls_octave;
  logic               note_valid_q, note_valid_d;

  logic [CNT_W-1:0]   meas_period, diff, tol;

  // Synchronizer survives ena low so the edge detector never sees a false rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= tone_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rise = s2_q & ~prev_q;

  tone_note_classify #(
    .CNT_W (CNT_W)
  ) u_classify (
    .period_i (period_q),
    .note_o   (cls_note),
    .octave_o (cls_octave)
  );

  always_comb begin
    // An edge coinciding with the counter maximum saturates rather than wraps.
    meas_period = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    diff        = (meas_period >= prev_period_q) ? meas_period - prev_period_q
                                                 : prev_period_q - meas_period;
    tol         = prev_period_q >> TOL_SHIFT;

    state_d        = state_q;
    cnt_d          = cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    silence_d      = silence_q;
    stable_d       = stable_q;
    prev_period_d  = prev_period_q;
    have_prev_d    = have_prev_q;
    note_d         = note_q;
    octave_d       = octave_q;
    note_valid_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d   = MEASURE;
          silence_d = 1'b0;
        end
      end
      MEASURE: begin
        if (rise) begin
          cnt_d          = '0;
          period_d       = meas_period;
          period_valid_d = 1'b1;
          if (have_prev_q && (diff <= tol)) begin
            stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + 4'd1;
          end else begin
            stable_d = 4'd1;
          end
          locked_d      = (stable_d == STABLE_MAX);
          prev_period_d = meas_period;
          have_prev_d   = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
          state_d     = IDLE;
          cnt_d       = '0;
          silence_d   = 1'b1;
          locked_d    = 1'b0;
          stable_d    = '0;
          have_prev_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (period_valid_q) begin
      note_d       = cls_note;
      octave_d     = cls_octave;
      note_valid_d = 1'b1;
    end

    if (!ena) begin
      state_d        = IDLE;
      cnt_d          = '0;
      period_d       = '0;
      period_valid_d = 1'b0;
      locked_d       = 1'b0;
      silence_d      = 1'b1;
      stable_d       = '0;
      prev_period_d  = '0;
      have_prev_d    = 1'b0;
      note_d         = '0;
      octave_d       = '0;
      note_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      silence_q      <= 1'b1;
      stable_q       <= '0;
      prev_period_q  <= '0;
      have_prev_q    <= 1'b0;
      note_q         <= '0;
      octave_q       <= '0;
      note_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      silence_q      <= silence_d;
      stable_q       <= stable_d;
      prev_period_q  <= prev_period_d;
      have_prev_q    <= have_prev_d;
      note_q         <= note_d;
      octave_q       <= octave_d;
      note_valid_q   <= note_valid_d;
    end
  end

  assign period_o       = period_q;
  assign period_valid_o = period_valid_q;
  assign locked_o       = locked_q;
  assign silence_o      = silence_q;
  assign note_o         = note_q;
  assign octave_o       = octave_q;
  assign note_valid_o   = note_valid_q;

endmodule
